plot_arbiter: RTL

- Shares the single `vga_adapter` pixel write port (x, y, colour, plot) between several pixel-producing renderers, e.g. runner/obstacle scanner, score overlay and screen-clear engine.
- Grants one requester at a time, in round-robin order, for a burst of pixels.
- Registers the granted pixel onto the adapter port and enforces a maximum burst length so that no renderer starves the others.
- Sits between the renderers and `vga_adapter` in the top level.

---
 rtl/plot_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Shares the single vga_adapter pixel write port between NUM_REQ renderers.
//   One requester at a time is granted a burst of pixels in round-robin order.
//   The granted requester's pixel is registered onto x/y/colour/plot. A burst
//   ends on the requester's last pixel, after MAX_BURST pixels, or when the
//   requester drops req. Every burst is followed by one dead cycle (S_GAP) and
//   one arbitration cycle (S_IDLE).
//
// Build option:
//   PLOT_ARB_FIXED_PRIORITY_EN - when defined, the lowest-index requester wins
//   and no round-robin pointer exists. Everything else is unchanged.
//
// Ports:
//   clk        system clock (CLOCK_50 domain)
//   reset      synchronous, active-high reset
//   hold       blocks new grants; a burst in progress is unaffected
//   req        per-requester request, held high while pixels are offered
//   last       per-requester final-pixel marker, qualified by req
//   x_in       packed x, requester i at [i*X_W +: X_W]
//   y_in       packed y, same packing
//   colour_in  packed colour, same packing
//   gnt        one-hot grant; requester i advances when gnt[i] & req[i]
//   x, y       registered pixel coordinates to vga_adapter
//   colour     registered pixel colour to vga_adapter
//   plot       registered write strobe to vga_adapter
//   busy       high whenever the arbiter is not idle
module plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 652,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     last,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*C_W-1:0] colour_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   plot,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [PW-1:0]        r_win;
    logic [PW-1:0]        w_win_nxt;
    logic [PW-1:0]        w_sel;
    logic                 w_found;

    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;

    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic                 w_plot_nxt;
    logic [X_W-1:0]       w_x_nxt;
    logic [Y_W-1:0]       w_y_nxt;
    logic [C_W-1:0]       w_c_nxt;

    logic                 w_start;
    logic                 w_req_w;
    logic                 w_last_w;
    logic                 w_at_max;
    logic                 w_release;

`ifndef PLOT_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        w_ptr_nxt;
    logic [PW-1:0]        w_ptr_inc;

    // Requester index at offset 'off' from the round-robin base, modulo NUM_REQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                             input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return PW'(s % NUM_REQ);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Winner search
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef PLOT_ARB_FIXED_PRIORITY_EN
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_sel   = PW'(k);
            end
`else
            if (!w_found && req[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = rr_idx(r_ptr, k);
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Burst qualifiers for the current owner
    // ------------------------------------------------------------------
    assign w_req_w   = req[r_win];
    assign w_last_w  = last[r_win];
    assign w_at_max  = (r_cnt == CW'(MAX_BURST - 1));
    assign w_start   = (r_state == S_IDLE) && !hold && w_found;
    // last and the burst limit in the same cycle collapse into one release.
    assign w_release = (r_state == S_GRANT) && (!w_req_w || w_last_w || w_at_max);

`ifndef PLOT_ARB_FIXED_PRIORITY_EN
    assign w_ptr_inc = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)   w_state_nxt = S_GRANT;
            S_GRANT: if (w_release) w_state_nxt = S_GAP;
            S_GAP:                  w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_nxt  = gnt;
        w_plot_nxt = 1'b0;
        w_x_nxt    = x;
        w_y_nxt    = y;
        w_c_nxt    = colour;
        w_cnt_nxt  = r_cnt;
        w_win_nxt  = r_win;
`ifndef PLOT_ARB_FIXED_PRIORITY_EN
        w_ptr_nxt  = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_gnt_nxt = NUM_REQ'(1) << w_sel;
                    w_win_nxt = w_sel;
                    w_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_req_w) begin
                    w_x_nxt    = x_in[32'(r_win) * X_W +: X_W];
                    w_y_nxt    = y_in[32'(r_win) * Y_W +: Y_W];
                    w_c_nxt    = colour_in[32'(r_win) * C_W +: C_W];
                    w_plot_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
                if (w_release) begin
                    w_gnt_nxt = '0;
`ifndef PLOT_ARB_FIXED_PRIORITY_EN
                    w_ptr_nxt = w_ptr_inc;
`endif
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            r_cnt  <= '0;
            r_win  <= '0;
`ifndef PLOT_ARB_FIXED_PRIORITY_EN
            r_ptr  <= '0;
`endif
        end else begin
            gnt    <= w_gnt_nxt;
            plot   <= w_plot_nxt;
            x      <= w_x_nxt;
            y      <= w_y_nxt;
            colour <= w_c_nxt;
            r_cnt  <= w_cnt_nxt;
            r_win  <= w_win_nxt;
`ifndef PLOT_ARB_FIXED_PRIORITY_EN
            r_ptr  <= w_ptr_nxt;
`endif
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
